// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

    // Wide constants; users slice them down to the LED bank width.
    localparam logic [63:0] SEED_ONEHOT = 64'h0000_0000_0000_0001;
    localparam logic [63:0] SEED_BLINK  = '1;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Button/LED signal bundle between the debounced button logic and the sequencer.
// mode_next/speed_next are one-cycle pulses with no ready (always accepted);
// tick acts as a valid strobe marking the cycle a new led value appears.
interface led_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             mode_next;
    logic             speed_next;
    logic             pause;
    logic [WIDTH-1:0] led;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic             tick;
    logic             dbg_dir;

    modport master (
        output mode_next, speed_next, pause,
        input  led, mode, speed, tick, dbg_dir
    );

    modport slave (
        input  mode_next, speed_next, pause,
        output led, mode, speed, tick, dbg_dir
    );
endinterface

// File: rtl/led_seq_ctrl_prescaler.sv
// Step-rate prescaler: period is BASE_DIV >> speed clock cycles.
module led_prescaler #(
    parameter int unsigned BASE_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       wrap
);
    logic [31:0] count_q;
    logic [31:0] limit;

    assign limit = (32'(BASE_DIV) >> speed) - 32'd1;
    assign wrap  = en && !clr && (count_q == limit);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= (count_q == limit) ? 32'd0 : count_q + 32'd1;
        end
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: mode/speed selection from button pulses, pattern stepping on prescaler wrap.
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter int unsigned BASE_DIV = 5000000
) (
    input  logic clk,
    input  logic rst,
    led_seq_ctrl_if.slave bus
);
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d, step_dir;
    logic [1:0]       speed_q, speed_d;
    logic [WIDTH-1:0] led_q, led_d, step_led;
    logic             tick_q, tick_d;
    logic             wrap;

    led_prescaler #(.BASE_DIV(BASE_DIV)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (!bus.pause),
        .clr   (bus.mode_next || bus.speed_next),
        .speed (speed_q),
        .wrap  (wrap)
    );

    // Pattern step function; the bounce turns around on the end bit so it dwells one period.
    always_comb begin
        step_led = led_q;
        step_dir = dir_q;
        unique case (mode_q)
            ROT_L:  step_led = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            ROT_R:  step_led = {led_q[0], led_q[WIDTH-1:1]};
            BOUNCE: begin
                if (dir_q == LEFT) begin
                    if (led_q[WIDTH-1]) begin
                        step_dir = RIGHT;
                        step_led = led_q >> 1;
                    end else begin
                        step_led = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        step_dir = LEFT;
                        step_led = led_q << 1;
                    end else begin
                        step_led = led_q >> 1;
                    end
                end
            end
            BLINK:  step_led = ~led_q;
            default: step_led = led_q;
        endcase
        if (mode_q != BLINK && led_q == '0) begin
            step_led = SEED_ONEHOT[WIDTH-1:0];
        end
    end

    // Button pulses override a step due in the same cycle (wrap is already masked by clr).
    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        led_d   = led_q;
        tick_d  = wrap;
        if (wrap) begin
            led_d = step_led;
            dir_d = step_dir;
        end
        if (bus.speed_next) begin
            speed_d = speed_q + 2'd1;
        end
        if (bus.mode_next) begin
            mode_d = mode_e'(mode_q + 2'd1);
            led_d  = (mode_d == BLINK) ? SEED_BLINK[WIDTH-1:0] : SEED_ONEHOT[WIDTH-1:0];
            dir_d  = LEFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= ROT_L;
            speed_q <= 2'd0;
            dir_q   <= LEFT;
            led_q   <= SEED_ONEHOT[WIDTH-1:0];
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.led     = led_q;
    assign bus.mode    = mode_q;
    assign bus.speed   = speed_q;
    assign bus.tick    = tick_q;
    assign bus.dbg_dir = dir_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized scoreboard bench for led_seq_ctrl against a step-count reference model.
module tb_led_seq_ctrl;
    localparam int W  = 16;
    localparam int BD = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_seq_ctrl_if #(.WIDTH(W)) bus ();

    led_seq_ctrl #(.WIDTH(W), .BASE_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    // State is kept abstractly: steps taken since the last seed and active
    // cycles elapsed in the current period; led is derived arithmetically.
    int   m_mode, m_speed, m_n, m_el;
    logic m_tick;

    logic [20:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] model_led(input int md, input int n);
        int m, idx;
        logic [15:0] one;
        one = 16'h0001;
        case (md)
            0: return one << (n % 16);
            1: return one << ((16 - (n % 16)) % 16);
            2: begin
                m   = n % 30;
                idx = (m < 16) ? m : 30 - m;
                return one << idx;
            end
            default: return ((n % 2) == 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic model_update(input logic r, input logic mn, input logic sn, input logic p);
        int per;
        if (r) begin
            m_mode = 0; m_speed = 0; m_n = 0; m_el = 0; m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (mn || sn) begin
                if (mn) begin
                    m_mode = (m_mode + 1) % 4;
                    m_n    = 0;
                end
                if (sn) m_speed = (m_speed + 1) % 4;
                m_el = 0;
            end else if (!p) begin
                per  = BD / (1 << m_speed);
                m_el = m_el + 1;
                if (m_el == per) begin
                    m_el   = 0;
                    m_n    = m_n + 1;
                    m_tick = 1'b1;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic mn, input logic sn, input logic p);
        rst            = r;
        bus.mode_next  = mn;
        bus.speed_next = sn;
        bus.pause      = p;
        model_update(r, mn, sn, p);
        exp_q.push_back({m_tick, 2'(m_speed), 2'(m_mode), model_led(m_mode, m_n)});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [20:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led",   bus.led,                e[15:0]);
            check("mode",  {14'd0, bus.mode},      {14'd0, e[17:16]});
            check("speed", {14'd0, bus.speed},     {14'd0, e[19:18]});
            check("tick",  {15'd0, bus.tick},      {15'd0, e[20]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic p_lvl;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(140);                                   // ROT_L full cycle

        drive(1'b0, 1'b0, 1'b1, 1'b0); idle(40);     // speed 1
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0); idle(30); // speeds 2, 3, wrap to 0
        end

        for (int i = 0; i < 4; i++) begin            // ROT_R, BOUNCE, BLINK, back to ROT_L
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            idle((i == 1) ? 250 : 40);
        end

        drive(1'b0, 1'b1, 1'b0, 1'b0); idle(5);      // pause at count=5
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(12);

        drive(1'b0, 1'b1, 1'b0, 1'b0); idle(7);      // mode_next on the wrap cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0); idle(10);
        drive(1'b0, 1'b1, 1'b1, 1'b0); idle(20);     // both pulses together

        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0); idle(60);     // into BOUNCE
        drive(1'b1, 1'b0, 1'b0, 1'b0); idle(20);     // reset mid-bounce

        p_lvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) p_lvl = ~p_lvl;
            drive($urandom_range(0, 499) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 59) == 0,
                  p_lvl);
        end
        idle(4);

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d required=0 entries left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
